// File: rtl/mult_seq_pkg.sv
// Shared types and default sizing for the multiplier operand sequencer.
// Default sizing matches a typical 8x8 signed multiplier with a short queue in front of it.
package mult_seq_pkg;

   localparam int TAMANO_DEF  = 8;
   localparam int DEPTH_DEF   = 4;
   localparam int TIMEOUT_DEF = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      HOLD   = 2'd3
   } seq_state_e;

endpackage

// File: rtl/mult_operand_fifo.sv
// Small power-of-two FIFO holding packed {A,B} operand pairs ahead of the sequencer.
// A push is refused whenever the FIFO is full, even when a pop happens on the same edge.
module mult_operand_fifo
   import mult_seq_pkg::*;
#(
   parameter int WIDTH = 2 * TAMANO_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   output logic                       full_o,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [AW:0]      count_q;
   logic             doPush;
   logic             doPop;

   // DEPTH is a power of two, so the top count bit alone marks "full".
   assign full_o  = count_q[AW];
   assign doPush  = push_i && !full_o;
   assign doPop   = pop_i && (count_q != '0);
   assign data_o  = mem_q[rdPtr_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

   // Pointers wrap naturally at DEPTH because their width is exactly log2(DEPTH).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mult_operand_sequencer.sv
// Feeds queued signed operand pairs to an external multiplier one at a time,
// waits for its completion edge (with timeout) and holds the product for a consumer.
module mult_operand_sequencer
   import mult_seq_pkg::*;
#(
   parameter int tamano  = TAMANO_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                      CLOCK,
   input  logic                      RESET,
   input  logic                      IN_VALID,
   output logic                      IN_READY,
   input  logic [tamano-1:0]         IN_A,
   input  logic [tamano-1:0]         IN_B,
   output logic                      START,
   output logic [tamano-1:0]         A,
   output logic [tamano-1:0]         B,
   input  logic                      END_MULT,
   input  logic [2*tamano-1:0]       S,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY,
   output logic [2*tamano-1:0]       OUT_S,
   output logic                      BUSY,
   output logic [$clog2(DEPTH):0]    COUNT,
   output logic                      ERR
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   seq_state_e             state_q;
   logic                   start_q;
   logic [tamano-1:0]      a_q;
   logic [tamano-1:0]      b_q;
   logic                   outValid_q;
   logic [2*tamano-1:0]    outS_q;
   logic                   err_q;
   logic                   endPrev_q;
   logic [TW-1:0]          tmo_q;

   logic [2*tamano-1:0]    fifoIn;
   logic [2*tamano-1:0]    fifoHead;
   logic                   fifoFull;
   logic [CW-1:0]          fifoCount;
   logic                   popReq;
   logic                   endRise;

   assign fifoIn  = {IN_A, IN_B};
   assign popReq  = (state_q == IDLE) && (fifoCount != '0);
   assign endRise = END_MULT && !endPrev_q;

   mult_operand_fifo #(
      .WIDTH (2 * tamano),
      .DEPTH (DEPTH)
   ) uFifo (
      .clk_i   (CLOCK),
      .rst_i   (RESET),
      .push_i  (IN_VALID),
      .data_i  (fifoIn),
      .full_o  (fifoFull),
      .pop_i   (popReq),
      .data_o  (fifoHead),
      .count_o (fifoCount)
   );

   // START is registered out of LAUNCH, so the multiplier sees it in the first WAIT
   // cycle; the END_MULT history resets high so a level left over from before reset
   // can never be mistaken for a fresh completion edge.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         start_q    <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         outValid_q <= 1'b0;
         outS_q     <= '0;
         err_q      <= 1'b0;
         endPrev_q  <= 1'b1;
         tmo_q      <= '0;
      end else begin
         start_q   <= 1'b0;
         endPrev_q <= END_MULT;
         case (state_q)
            IDLE: begin
               if (popReq) begin
                  a_q     <= fifoHead[2*tamano-1:tamano];
                  b_q     <= fifoHead[tamano-1:0];
                  state_q <= LAUNCH;
               end
            end
            LAUNCH: begin
               start_q <= 1'b1;
               tmo_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (endRise) begin
                  outS_q     <= S;
                  outValid_q <= 1'b1;
                  state_q    <= HOLD;
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            HOLD: begin
               if (OUT_READY) begin
                  outValid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign IN_READY  = !fifoFull;
   assign START     = start_q;
   assign A         = a_q;
   assign B         = b_q;
   assign OUT_VALID = outValid_q;
   assign OUT_S     = outS_q;
   assign BUSY      = (state_q != IDLE);
   assign COUNT     = fifoCount;
   assign ERR       = err_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Randomized self-checking bench: a transaction-level model of the sequencer plus a
// behavioural multiplier stub, with directed cases pinning products, latency and timeout.
module tb_mult_operand_sequencer;

   localparam int W       = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;
   localparam int CW      = $clog2(DEPTH) + 1;

   localparam int P_IDLE   = 0;
   localparam int P_LAUNCH = 1;
   localparam int P_WAIT   = 2;
   localparam int P_HOLD   = 3;

   logic              CLOCK = 1'b0;
   logic              RESET;
   logic              IN_VALID;
   logic              IN_READY;
   logic [W-1:0]      IN_A;
   logic [W-1:0]      IN_B;
   logic              START;
   logic [W-1:0]      A;
   logic [W-1:0]      B;
   logic              END_MULT;
   logic [2*W-1:0]    S;
   logic              OUT_VALID;
   logic              OUT_READY;
   logic [2*W-1:0]    OUT_S;
   logic              BUSY;
   logic [CW-1:0]     COUNT;
   logic              ERR;

   int total = 0;
   int bad   = 0;
   int startCount = 0;

   always #5 CLOCK = ~CLOCK;

   mult_operand_sequencer #(
      .tamano  (W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_A      (IN_A),
      .IN_B      (IN_B),
      .START     (START),
      .A         (A),
      .B         (B),
      .END_MULT  (END_MULT),
      .S         (S),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_S     (OUT_S),
      .BUSY      (BUSY),
      .COUNT     (COUNT),
      .ERR       (ERR)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] signedProduct(input logic [W-1:0] a, input logic [W-1:0] b);
      int ia;
      int ib;
      int p;
      ia = $signed(a);
      ib = $signed(b);
      p  = ia * ib;
      return p[2*W-1:0];
   endfunction

   // Reference model: a queue of accepted pairs and the single job in flight.
   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } pair_t;

   pair_t          mQueue[$];
   pair_t          mHead;
   int             mPhase = P_IDLE;
   int             mWaited = 0;
   bit             mPrevEnd = 1'b1;
   bit             mStart = 1'b0;
   bit             mOutValid = 1'b0;
   bit             mErr = 1'b0;
   bit             mAccept;
   bit             mRise;
   logic [W-1:0]   mA = '0;
   logic [W-1:0]   mB = '0;
   logic [2*W-1:0] mOutS = '0;

   initial forever begin
      @(posedge CLOCK or posedge RESET);
      if (RESET) begin
         mQueue.delete();
         mPhase    = P_IDLE;
         mWaited   = 0;
         mPrevEnd  = 1'b1;
         mStart    = 1'b0;
         mOutValid = 1'b0;
         mErr      = 1'b0;
         mA        = '0;
         mB        = '0;
         mOutS     = '0;
      end else begin
         mAccept = IN_VALID && (mQueue.size() < DEPTH);
         mRise   = END_MULT && !mPrevEnd;
         mStart  = 1'b0;
         case (mPhase)
            P_IDLE: begin
               if (mQueue.size() > 0) begin
                  mHead  = mQueue.pop_front();
                  mA     = mHead.a;
                  mB     = mHead.b;
                  mPhase = P_LAUNCH;
               end
            end
            P_LAUNCH: begin
               mStart  = 1'b1;
               mWaited = 0;
               mPhase  = P_WAIT;
            end
            P_WAIT: begin
               if (mRise) begin
                  mOutS     = S;
                  mOutValid = 1'b1;
                  mPhase    = P_HOLD;
               end else if (mWaited == TIMEOUT - 1) begin
                  mErr   = 1'b1;
                  mPhase = P_IDLE;
               end else begin
                  mWaited++;
               end
            end
            default: begin
               if (OUT_READY) begin
                  mOutValid = 1'b0;
                  mPhase    = P_IDLE;
               end
            end
         endcase
         if (mAccept) mQueue.push_back({IN_A, IN_B});
         mPrevEnd = END_MULT;
      end
   end

   // Every cycle out of reset, all outputs are compared against the model.
   initial forever begin
      @(negedge CLOCK);
      if (!RESET) begin
         checkOutput("in_ready",  IN_READY,  mQueue.size() < DEPTH);
         checkOutput("count",     COUNT,     mQueue.size());
         checkOutput("start",     START,     mStart);
         checkOutput("busy",      BUSY,      mPhase != P_IDLE);
         checkOutput("err",       ERR,       mErr);
         checkOutput("out_valid", OUT_VALID, mOutValid);
         checkOutput("out_s",     OUT_S,     mOutS);
         checkOutput("a",         A,         mA);
         checkOutput("b",         B,         mB);
      end
   end

   initial forever begin
      @(negedge CLOCK);
      if (!RESET && START) startCount++;
   end

   // Multiplier stub: random latency, END_MULT high 1-3 cycles, S is noise otherwise.
   logic [2*W-1:0] stubProd;
   logic [31:0]    stubRnd;
   int             stubDelay = 0;
   int             stubHigh = 0;
   bit             stubPending = 1'b0;
   bit             stubDead = 1'b0;
   bit             stubRandDrop = 1'b0;

   initial forever begin
      @(negedge CLOCK);
      if (RESET) begin
         END_MULT    = 1'b0;
         S           = '0;
         stubPending = 1'b0;
         stubHigh    = 0;
      end else begin
         if (stubHigh > 0) begin
            stubHigh--;
            if (stubHigh == 0) END_MULT = 1'b0;
         end else if (stubPending) begin
            if (stubDelay == 0) begin
               END_MULT    = 1'b1;
               S           = stubProd;
               stubHigh    = $urandom_range(1, 3);
               stubPending = 1'b0;
            end else begin
               stubDelay--;
            end
         end
         if (!END_MULT) begin
            stubRnd = $urandom;
            S = stubRnd[2*W-1:0];
         end
         if (START && !stubDead && !(stubRandDrop && $urandom_range(0, 15) == 0)) begin
            stubPending = 1'b1;
            stubDelay   = $urandom_range(0, 3);
            stubProd    = signedProduct(A, B);
         end
      end
   end

   task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic rdy);
      IN_VALID  = v;
      IN_A      = a;
      IN_B      = b;
      OUT_READY = rdy;
      @(negedge CLOCK);
   endtask

   task automatic waitForValid(input string name);
      int n;
      n = 0;
      while (!OUT_VALID && n < 200) begin
         @(negedge CLOCK);
         n++;
      end
      checkOutput(name, OUT_VALID, 1'b1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      while ((BUSY || COUNT != 0) && n < 2000) begin
         @(negedge CLOCK);
         n++;
      end
      checkOutput("drain_idle", BUSY, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int s0;
      int n;
      logic [31:0] r1;
      logic [31:0] r2;

      RESET     = 1'b1;
      IN_VALID  = 1'b0;
      IN_A      = '0;
      IN_B      = '0;
      OUT_READY = 1'b0;
      END_MULT  = 1'b0;
      S         = '0;
      repeat (3) @(negedge CLOCK);
      checkOutput("rst_count",     COUNT,     0);
      checkOutput("rst_start",     START,     0);
      checkOutput("rst_busy",      BUSY,      0);
      checkOutput("rst_err",       ERR,       0);
      checkOutput("rst_out_valid", OUT_VALID, 0);
      checkOutput("rst_out_s",     OUT_S,     0);
      checkOutput("rst_a",         A,         0);
      RESET = 1'b0;
      @(negedge CLOCK);
      checkOutput("rst_in_ready", IN_READY, 1);

      $display("[TB] 7 x -3 with launch latency");
      s0 = startCount;
      applyStimulus(1'b1, 8'd7, 8'hFD, 1'b0);
      checkOutput("lat_e0", START, 0);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
      checkOutput("lat_e1", START, 0);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
      checkOutput("lat_e2", START, 1);
      waitForValid("mul_7_m3_valid");
      checkOutput("mul_7_m3", OUT_S, 16'hFFEB);
      checkOutput("one_start", startCount - s0, 1);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
      checkOutput("handshake_clears", OUT_VALID, 0);

      $display("[TB] extreme operands");
      applyStimulus(1'b1, 8'h80, 8'h80, 1'b0);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
      waitForValid("mul_m128_m128_valid");
      checkOutput("mul_m128_m128", OUT_S, 16'h4000);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
      applyStimulus(1'b1, 8'd127, 8'h80, 1'b0);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
      waitForValid("mul_127_m128_valid");
      checkOutput("mul_127_m128", OUT_S, 16'hC080);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
      drain();

      $display("[TB] backpressure and hold");
      for (int i = 0; i < 10; i++) begin
         r1 = $urandom;
         r2 = $urandom;
         applyStimulus(1'b1, r1[W-1:0], r2[W-1:0], 1'b0);
      end
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
      waitForValid("fill_valid");
      checkOutput("fill_count", COUNT, 4);
      checkOutput("fill_ready", IN_READY, 0);
      s0 = startCount;
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
      checkOutput("hold_no_start", startCount - s0, 0);
      checkOutput("hold_valid", OUT_VALID, 1);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
      checkOutput("release_start_h0", START, 0);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
      checkOutput("release_start_h1", START, 0);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b0);
      checkOutput("release_start_h2", START, 1);
      drain();

      $display("[TB] timeout");
      stubDead = 1'b1;
      applyStimulus(1'b1, 8'd3, 8'd5, 1'b1);
      applyStimulus(1'b1, 8'hF0, 8'd9, 1'b1);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
      n = 0;
      while (!START && n < 20) begin
         @(negedge CLOCK);
         n++;
      end
      checkOutput("to_start_seen", START, 1);
      n = 0;
      do begin
         @(negedge CLOCK);
         n++;
      end while (!ERR && n < 200);
      checkOutput("to_cycles", n, TIMEOUT);
      checkOutput("to_idle", BUSY, 0);
      checkOutput("to_no_valid", OUT_VALID, 0);
      stubDead = 1'b0;
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
      checkOutput("to_next_h1", START, 0);
      applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
      checkOutput("to_next_h2", START, 1);
      waitForValid("to_next_valid");
      checkOutput("to_next_prod", OUT_S, 16'hFF70);
      drain();
      checkOutput("err_sticky", ERR, 1);

      $display("[TB] reset while waiting");
      stubDead = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(i + 1), 8'(i + 2), 1'b0);
      IN_VALID = 1'b0;
      checkOutput("mid_count", COUNT, 3);
      checkOutput("mid_busy", BUSY, 1);
      #2;
      RESET = 1'b1;
      #1;
      checkOutput("mid_rst_count",     COUNT,     0);
      checkOutput("mid_rst_start",     START,     0);
      checkOutput("mid_rst_out_valid", OUT_VALID, 0);
      checkOutput("mid_rst_busy",      BUSY,      0);
      checkOutput("mid_rst_err",       ERR,       0);
      checkOutput("mid_rst_in_ready",  IN_READY,  1);
      @(negedge CLOCK);
      RESET    = 1'b0;
      stubDead = 1'b0;
      s0 = startCount;
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
      checkOutput("no_start_after_rst", startCount - s0, 0);

      $display("[TB] random traffic");
      stubRandDrop = 1'b1;
      for (int i = 0; i < 800; i++) begin
         r1 = $urandom;
         r2 = $urandom;
         if (r1[31:29] == 3'd0) r1[W-1:0] = 8'h80;
         if (r2[31:29] == 3'd1) r2[W-1:0] = 8'h7F;
         applyStimulus(r1[16], r1[W-1:0], r2[W-1:0], r2[17] | r2[18]);
      end
      stubRandDrop = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
